// File: rtl/div_pkg.sv
// Shared definitions for the divider sequencing front end: operation
// encodings, controller states, default width and the two RISC-V
// special-case bit patterns.
package div_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [XLEN_DEF-1:0] INT_MIN  = {1'b1, {(XLEN_DEF-1){1'b0}}};
  localparam logic [XLEN_DEF-1:0] ALL_ONES = {XLEN_DEF{1'b1}};

  // funct3[1:0] of the M-extension divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_FIN  = 2'b10
  } div_state_e;

  // DIV and REM treat their operands as two's complement
  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // REM and REMU return the remainder rather than the quotient
  function automatic logic isRemOp(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's complement on one or more independent lanes. Used to
// strip signs off the operands before the unsigned core and to put the
// sign back on the core's answer.
module div_sign_fix #(
  parameter int W     = 32,
  parameter int LANES = 1
) (
  input  logic [LANES-1:0][W-1:0] value_i,
  input  logic [LANES-1:0]        negate_i,
  output logic [LANES-1:0][W-1:0] value_o
);

  // Each lane is negated only when its flag is set; INT_MIN maps to itself,
  // which is exactly the unsigned magnitude the core expects.
  always_comb begin
    value_o = value_i;
    for (int i = 0; i < LANES; i++) begin
      if (negate_i[i]) begin
        value_o[i] = ~value_i[i] + W'(1);
      end
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequencing front end for the pipelined unsigned divider core. Accepts one
// DIV/DIVU/REM/REMU request, answers divide-by-zero and signed overflow on
// its own, otherwise hands magnitudes to the core, waits out its latency,
// re-signs the answer and pulses done with the result.
module div_ctrl
  import div_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int CORE_LAT = 34
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] core_dividend,
  output logic [XLEN-1:0] core_divisor,
  output logic            core_valid,
  input  logic [XLEN-1:0] core_quot,
  input  logic [XLEN-1:0] core_rem,
  input  logic            core_ready
);

  localparam int CNT_W = $clog2(CORE_LAT + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             remSel_q, remSel_d;
  logic             negQuot_q, negQuot_d;
  logic             negRem_q, negRem_d;
  logic [XLEN-1:0]  dividend_q, dividend_d;
  logic [XLEN-1:0]  divisor_q, divisor_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic                 accept;
  logic                 signedReq;
  logic                 remReq;
  logic                 divZero;
  logic                 overflow;
  logic [XLEN-1:0]      specialResult;
  logic [1:0][XLEN-1:0] opsRaw;
  logic [1:0][XLEN-1:0] opsMag;
  logic [1:0]           opsNeg;
  logic [0:0][XLEN-1:0] coreSel;
  logic [0:0][XLEN-1:0] coreSigned;
  logic [0:0]           coreNeg;

  assign signedReq = isSignedOp(op);
  assign remReq    = isRemOp(op);
  assign divZero   = (rs2 == '0);
  assign overflow  = signedReq && (rs1 == INT_MIN) && (rs2 == ALL_ONES);

  // A request is only taken between operations, and a flush always wins.
  assign accept = start && !kill && ((state_q == ST_IDLE) || (state_q == ST_FIN));

  // Divide-by-zero takes priority over overflow (rs2 == 0 cannot overflow).
  assign specialResult = divZero ? (remReq ? rs1 : ALL_ONES)
                                 : (remReq ? '0  : INT_MIN);

  // Lane 0 is the dividend, lane 1 the divisor.
  assign opsRaw = {rs2, rs1};
  assign opsNeg = {signedReq && rs2[XLEN-1], signedReq && rs1[XLEN-1]};

  div_sign_fix #(
    .W     (XLEN),
    .LANES (2)
  ) u_opMag (
    .value_i  (opsRaw),
    .negate_i (opsNeg),
    .value_o  (opsMag)
  );

  // Select quotient or remainder first so one negator serves both.
  assign coreSel[0] = remSel_q ? core_rem : core_quot;
  assign coreNeg[0] = remSel_q ? negRem_q : negQuot_q;

  div_sign_fix #(
    .W     (XLEN),
    .LANES (1)
  ) u_resSign (
    .value_i  (coreSel),
    .negate_i (coreNeg),
    .value_o  (coreSigned)
  );

  // Next-state and datapath update: countdown in WAIT, capture from the core,
  // accept of a new request, and flush override last so it dominates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    remSel_d   = remSel_q;
    negQuot_d  = negQuot_q;
    negRem_d   = negRem_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (core_ready) begin
          result_d = coreSigned[0];
          state_d  = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (accept) begin
      remSel_d   = remReq;
      negQuot_d  = signedReq && (rs1[XLEN-1] ^ rs2[XLEN-1]);
      negRem_d   = signedReq && rs1[XLEN-1];
      dividend_d = opsMag[0];
      divisor_d  = opsMag[1];
      if (divZero || overflow) begin
        result_d = specialResult;
        state_d  = ST_FIN;
      end else begin
        cnt_d   = CNT_W'(CORE_LAT);
        state_d = ST_WAIT;
      end
    end

    if (kill) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // Controller state and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request bookkeeping, core operands and the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remSel_q   <= 1'b0;
      negQuot_q  <= 1'b0;
      negRem_q   <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
    end else begin
      remSel_q   <= remSel_d;
      negQuot_q  <= negQuot_d;
      negRem_q   <= negRem_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
    end
  end

  assign busy          = (state_q == ST_WAIT);
  assign core_valid    = (state_q == ST_WAIT);
  assign done          = (state_q == ST_FIN);
  assign result        = result_q;
  assign core_dividend = dividend_q;
  assign core_divisor  = divisor_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a table of known RISC-V divide cases,
// hand-written kill/reset/back-to-back sequences, then randomized requests
// scored against a plain-arithmetic reference of the M-extension rules.
module tb_div_ctrl;

  localparam int CORE_LAT = 34;
  localparam int MAX_WAIT = 300;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  opIn;
  logic [31:0] rs1In;
  logic [31:0] rs2In;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic        core_valid;
  logic [31:0] coreQuot;
  logic [31:0] coreRem;
  logic        coreReady;

  int checks;
  int failures;
  int coreCnt;
  int stallCycles;

  div_ctrl #(
    .XLEN     (32),
    .CORE_LAT (CORE_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (opIn),
    .rs1           (rs1In),
    .rs2           (rs2In),
    .kill          (kill),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .core_dividend (core_dividend),
    .core_divisor  (core_divisor),
    .core_valid    (core_valid),
    .core_quot     (coreQuot),
    .core_rem      (coreRem),
    .core_ready    (coreReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: plain unsigned division, valid once the operands have
  // been presented for CORE_LAT cycles plus any extra stall the test asks for.
  always @(posedge clk or posedge rst) begin
    if (rst) coreCnt <= 0;
    else if (core_valid) coreCnt <= coreCnt + 1;
    else coreCnt <= 0;
  end

  assign coreQuot  = (core_divisor == 32'd0) ? 32'd0 : core_dividend / core_divisor;
  assign coreRem   = (core_divisor == 32'd0) ? 32'd0 : core_dividend % core_divisor;
  assign coreReady = core_valid && (coreCnt >= CORE_LAT + stallCycles);

  // Reference answer from the RISC-V M-extension rules.
  function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit isRem;
    bit isSigned;
    int sa;
    int sb;
    isRem    = o[1];
    isSigned = !o[0];
    sa = a;
    sb = b;
    if (b == 32'd0) return isRem ? a : 32'hFFFF_FFFF;
    if (isSigned) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return isRem ? 32'd0 : 32'h8000_0000;
      return isRem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return isRem ? a % b : a / b;
  endfunction

  function automatic bit refSpecial(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] refMag(input logic [1:0] o, input logic [31:0] v);
    if (!o[0] && v[31]) return 32'(-v);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request at #1 after an edge, then follow it to done while
  // watching the core interface. Returns start-to-done latency in cycles.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input int stall, output int lat, output bit sawValid, output bit magOk);
    stallCycles = stall;
    start = 1'b1;
    opIn  = o;
    rs1In = a;
    rs2In = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat      = 1;
    sawValid = 1'b0;
    magOk    = 1'b1;
    while (!done && lat < MAX_WAIT) begin
      if (core_valid) begin
        sawValid = 1'b1;
        if (core_dividend !== refMag(o, a) || core_divisor !== refMag(o, b)) magOk = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runAndCheck(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input int stall, input logic [31:0] expRes, input int expLat, input bit expCore);
    int lat;
    bit sawValid;
    bit magOk;
    applyStimulus(o, a, b, stall, lat, sawValid, magOk);
    checkOutput({name, ".result"}, result, expRes);
    checkOutput({name, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, ".coreUsed"}, {31'd0, sawValid}, {31'd0, expCore});
    checkOutput({name, ".coreOperands"}, {31'd0, magOk}, 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    int          expLat;
    bit          expCore;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat;
    int doneCount;
    logic [31:0] prevRes;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          rstall;
    int          mode;

    checks      = 0;
    failures    = 0;
    stallCycles = 0;
    rst   = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    opIn  = 2'b00;
    rs1In = 32'd0;
    rs2In = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.done", {31'd0, done}, 32'd0);
    checkOutput("reset.result", result, 32'd0);
    checkOutput("reset.coreDividend", core_dividend, 32'd0);
    checkOutput("reset.coreDivisor", core_divisor, 32'd0);
    checkOutput("reset.coreValid", {31'd0, core_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed table");
    vecs[0]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 36, 1'b1};
    vecs[1]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 36, 1'b1};
    vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF, 36, 1'b1};
    vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'd2,        32'd1,         36, 1'b1};
    vecs[4]  = '{2'b00, 32'd5,         32'd0,        32'hFFFF_FFFF, 1,  1'b0};
    vecs[5]  = '{2'b10, 32'd5,         32'd0,        32'd5,         1,  1'b0};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0};
    vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b0};
    vecs[8]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         36, 1'b1};
    vecs[9]  = '{2'b00, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 36, 1'b1};
    vecs[10] = '{2'b10, 32'd100,       32'hFFFF_FFF9, 32'd2,         36, 1'b1};
    vecs[11] = '{2'b00, 32'h8000_0000, 32'd2,        32'hC000_0000, 36, 1'b1};
    for (int i = 0; i < 12; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0,
                  vecs[i].expRes, vecs[i].expLat, vecs[i].expCore);
    end

    $display("[TB] kill during WAIT");
    prevRes = result;
    stallCycles = 0;
    start = 1'b1; opIn = 2'b00; rs1In = 32'd1000; rs2In = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checkOutput("kill.busy", {31'd0, busy}, 32'd0);
    checkOutput("kill.coreValid", {31'd0, core_valid}, 32'd0);
    doneCount = 0;
    for (int c = 0; c < 45; c++) begin
      if (done) doneCount++;
      @(posedge clk); #1;
    end
    checkOutput("kill.noDone", 32'(doneCount), 32'd0);
    checkOutput("kill.result", result, prevRes);

    $display("[TB] reset during WAIT");
    start = 1'b1; opIn = 2'b01; rs1In = 32'd77; rs2In = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midReset.busy", {31'd0, busy}, 32'd0);
    checkOutput("midReset.coreValid", {31'd0, core_valid}, 32'd0);
    checkOutput("midReset.result", result, 32'd0);
    checkOutput("midReset.coreDividend", core_dividend, 32'd0);
    checkOutput("midReset.coreDivisor", core_divisor, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    doneCount = 0;
    for (int c = 0; c < 45; c++) begin
      if (done) doneCount++;
      @(posedge clk); #1;
    end
    checkOutput("midReset.noDone", 32'(doneCount), 32'd0);

    $display("[TB] back-to-back special cases");
    start = 1'b1; opIn = 2'b00; rs1In = 32'd7; rs2In = 32'd0;
    @(posedge clk); #1;
    checkOutput("b2b.firstDone", {31'd0, done}, 32'd1);
    checkOutput("b2b.firstResult", result, 32'hFFFF_FFFF);
    opIn = 2'b10; rs1In = 32'd9; rs2In = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("b2b.secondDone", {31'd0, done}, 32'd1);
    checkOutput("b2b.secondResult", result, 32'd9);
    @(posedge clk); #1;
    checkOutput("b2b.doneDrops", {31'd0, done}, 32'd0);
    @(posedge clk); #1;

    $display("[TB] start ignored during WAIT");
    start = 1'b1; opIn = 2'b01; rs1In = 32'd50; rs2In = 32'd5;
    @(posedge clk); #1;
    lat = 1;
    while (!done && lat < MAX_WAIT) begin
      if (lat == 5) begin
        start = 1'b1; opIn = 2'b10; rs1In = 32'd9; rs2In = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checkOutput("waitStart.result", result, 32'd10);
    checkOutput("waitStart.latency", 32'(lat), 32'd36);
    doneCount = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (done) doneCount++;
    end
    checkOutput("waitStart.extraDone", 32'(doneCount), 32'd0);

    $display("[TB] randomized requests");
    for (int i = 0; i < 25; i++) begin
      rop    = 2'($urandom_range(0, 3));
      ra     = $urandom;
      rb     = $urandom;
      rstall = $urandom_range(0, 3);
      mode   = $urandom_range(0, 9);
      if (mode == 0) rb = 32'd0;
      else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (mode == 2) rb = 32'($urandom_range(1, 15));
      else if (mode == 3) rb = 32'(-$urandom_range(1, 15));
      runAndCheck($sformatf("rand%0d", i), rop, ra, rb, rstall, refResult(rop, ra, rb),
                  refSpecial(rop, ra, rb) ? 1 : CORE_LAT + 2 + rstall, !refSpecial(rop, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
